intr_arbiter: RTL and testbench
===============================

Name: intr_arbiter

Overview:
- Arbitrates interrupt requests from the iopage devices (KW11L line clock, console TTY, disk, and others) onto the single CPU interrupt request/vector path.
- Picks the highest-priority eligible requester against the CPU's current PSW priority and presents its vector.
- Returns a one-cycle acknowledge pulse to the winning device when the CPU takes the trap.
- Sits between the device register blocks and the CPU trap sequencer.

Parameters:
- NUM_SRC, 4: number of interrupt sources; index 0 has the highest bus position.
- VEC_W, 8: vector width in bits (vectors are byte addresses 0-0377 octal).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- src_req  in  NUM_SRC  per-source interrupt request level (e.g. a device's int_enable && done)
- src_vector  in  VEC_W*NUM_SRC  per-source vector; source i occupies bits [VEC_W*i +: VEC_W]
- src_level  in  3*NUM_SRC  per-source BR level 0-7; source i occupies bits [3*i +: 3]
- cpu_ipl  in  3  current PSW priority bits 7:5
- cpu_int_ack  in  1  one-cycle pulse: CPU has committed to the presented interrupt
- cpu_int_req  out  1  interrupt pending to the CPU
- cpu_int_vector  out  VEC_W  vector of the granted source
- cpu_int_level  out  3  BR level of the granted source
- src_ack  out  NUM_SRC  one-hot, one-cycle acknowledge to the granted source

Behaviour:
- Eligibility: source i is eligible when src_req[i]=1 and src_level[i] > cpu_ipl (unsigned). A level-0 source is never eligible.
- Winner selection: highest src_level among eligible sources. On a level tie, the lowest index wins (daisy-chain order).
- FSM states: IDLE, PRESENT, HOLDOFF. Encoding lives in the shared package.
- IDLE:
  - If any source is eligible at a clock edge: latch grant index g, vector and level into registers; set cpu_int_req<=1; go to PRESENT.
  - Latency: request sampled at edge N gives cpu_int_req=1 after edge N.
- PRESENT:
  - Outputs are held stable from the latched registers. A higher-level source does not preempt the grant.
  - If cpu_int_ack=1: src_ack[g]<=1 for exactly one cycle; cpu_int_req<=0; go to HOLDOFF.
  - Else if src_req[g]=0 or src_level[g] <= cpu_ipl (withdrawal): cpu_int_req<=0; no src_ack; go to IDLE.
  - Ack and withdrawal in the same cycle: ack wins, because the CPU has already committed.
- HOLDOFF:
  - Lasts one cycle. src_ack clears; no arbitration. This gives the device a cycle to drop its request.
  - Then go to IDLE.
  - Back-to-back grants are therefore separated by at least 2 cycles of cpu_int_req=0.
- cpu_int_ack outside PRESENT is ignored: no src_ack, no state change.
- cpu_int_vector and cpu_int_level read 0 whenever cpu_int_req=0.
- Reset values: state=IDLE, cpu_int_req=0, cpu_int_vector=0, cpu_int_level=0, src_ack=0, grant index=0.
- Reset asserted mid-PRESENT or mid-HOLDOFF: return to IDLE on the next edge; any pending src_ack is suppressed.
- cpu_ipl changes during HOLDOFF have no effect; they are evaluated in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package intr_pkg:
  - FSM state encoding (IDLE, PRESENT, HOLDOFF).
  - Level width (3).
  - Default vectors: CLK_VEC=0100, TTI_VEC=060, TTO_VEC=064 (octal).
  - BR level constants BR4-BR7.
- One combinational sub-module, intr_prio_enc:
  - Inputs: src_req, src_level, cpu_ipl.
  - Outputs: any_eligible, winner index (clog2(NUM_SRC) bits).
  - The FSM and output registers stay in intr_arbiter.

Test Plan:
1. Single source (src 2, level 6, vector 0100, ipl 0) raises req -> cpu_int_req=1 the next cycle with vector 0100 and level 6; ack pulse -> src_ack=0100b for one cycle, cpu_int_req=0, then 1 HOLDOFF cycle.
2. Src 1 (level 4, vec 060) and src 3 (level 6, vec 0100) request together, ipl 0 -> src 3 granted. After its ack and req drop, src 1 is granted with vector 060.
3. Tie: src 0 and src 2 both at level 5 -> src 0 granted; src 2 granted after src 0's ack.
4. ipl=6 with a level-6 request -> no cpu_int_req. Lower ipl to 5 -> cpu_int_req=1 after one edge. Raise ipl to 7 while in PRESENT -> withdrawal, cpu_int_req=0, no src_ack.
5. Granted source drops req in the same cycle cpu_int_ack=1 -> src_ack still pulses for that source (ack wins). Separately, ack while IDLE -> no src_ack.
6. Reset asserted during PRESENT -> all outputs 0 on the next edge, no src_ack; with the request still held after reset releases, a re-grant occurs one edge later.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt arbiter slice.
// Holds the FSM state encoding, the BR level width, and the default
// iopage vectors and bus-request levels that device blocks hand to the arbiter.
package intr_pkg;

    localparam int unsigned LevelW = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPresent = 2'd1,
        StHoldoff = 2'd2
    } intr_state_e;

    // Default device vectors (octal byte addresses).
    localparam logic [7:0] ClkVec = 8'o100;
    localparam logic [7:0] TtiVec = 8'o060;
    localparam logic [7:0] TtoVec = 8'o064;

    // Bus-request levels.
    localparam logic [LevelW-1:0] Br4 = 3'd4;
    localparam logic [LevelW-1:0] Br5 = 3'd5;
    localparam logic [LevelW-1:0] Br6 = 3'd6;
    localparam logic [LevelW-1:0] Br7 = 3'd7;

endpackage

// File: rtl/intr_arbiter_if.sv
// Interrupt bus between the device register blocks / CPU trap sequencer and the arbiter.
//   src_req        per-source request level
//   src_vector     per-source vector, source i at [VEC_W*i +: VEC_W]
//   src_level      per-source BR level, source i at [3*i +: 3]
//   cpu_ipl        current PSW priority
//   cpu_int_ack    CPU commits to the presented interrupt (one-cycle pulse)
//   cpu_int_req    interrupt pending to the CPU
//   cpu_int_vector vector of the granted source (0 when no request)
//   cpu_int_level  BR level of the granted source (0 when no request)
//   src_ack        one-hot one-cycle acknowledge to the granted source
// Modport master is the device/CPU side, slave is the arbiter.
interface intr_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned VEC_W   = 8
);
    logic [NUM_SRC-1:0]       src_req;
    logic [VEC_W*NUM_SRC-1:0] src_vector;
    logic [3*NUM_SRC-1:0]     src_level;
    logic [2:0]               cpu_ipl;
    logic                     cpu_int_ack;
    logic                     cpu_int_req;
    logic [VEC_W-1:0]         cpu_int_vector;
    logic [2:0]               cpu_int_level;
    logic [NUM_SRC-1:0]       src_ack;

    modport master (
        output src_req, src_vector, src_level, cpu_ipl, cpu_int_ack,
        input  cpu_int_req, cpu_int_vector, cpu_int_level, src_ack
    );

    modport slave (
        input  src_req, src_vector, src_level, cpu_ipl, cpu_int_ack,
        output cpu_int_req, cpu_int_vector, cpu_int_level, src_ack
    );
endinterface

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder for interrupt sources.
//   src_req_i      per-source request
//   src_level_i    per-source BR level, source i at [LevelW*i +: LevelW]
//   cpu_ipl_i      current CPU priority
//   any_eligible_o some source has req=1 and level > ipl
//   winner_o       highest-level eligible source, lowest index on a tie
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IdxW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]        src_req_i,
    input  logic [LevelW*NUM_SRC-1:0] src_level_i,
    input  logic [LevelW-1:0]         cpu_ipl_i,
    output logic                      any_eligible_o,
    output logic [IdxW-1:0]           winner_o
);

    logic [LevelW-1:0] lvl;
    logic [LevelW-1:0] best;

    // Scan in daisy-chain order; strict '>' keeps the lowest index on a level tie.
    // Level 0 can never exceed an unsigned ipl, so it is never eligible.
    always_comb begin
        any_eligible_o = 1'b0;
        winner_o       = '0;
        best           = '0;
        lvl            = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            lvl = src_level_i[LevelW*i +: LevelW];
            if (src_req_i[i] && (lvl > cpu_ipl_i) && (!any_eligible_o || (lvl > best))) begin
                any_eligible_o = 1'b1;
                best           = lvl;
                winner_o       = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: picks the highest-priority eligible iopage source against the
// CPU's PSW priority, presents its vector/level, and pulses src_ack to it when the
// CPU takes the trap. All outputs are registered.
//   clk     system clock
//   reset   synchronous, active-high
//   bus_io  intr_arbiter_if slave side (requests/vectors/levels in, grant/acks out)
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned VEC_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    intr_arbiter_if.slave bus_io
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    intr_state_e          state_q, state_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [LevelW-1:0]    lvl_q, lvl_d;
    logic                 req_q, req_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;

    logic                 any_eligible;
    logic [IdxW-1:0]      winner;
    logic                 withdraw;

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .IdxW    (IdxW)
    ) u_prio_enc (
        .src_req_i      (bus_io.src_req),
        .src_level_i    (bus_io.src_level),
        .cpu_ipl_i      (bus_io.cpu_ipl),
        .any_eligible_o (any_eligible),
        .winner_o       (winner)
    );

    // The granted source has dropped its request or fallen to/below the CPU priority.
    assign withdraw = !bus_io.src_req[grant_q] ||
                      (bus_io.src_level[LevelW*grant_q +: LevelW] <= bus_io.cpu_ipl);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Ack is tested before withdrawal: the CPU has already committed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (any_eligible) state_d = StPresent;
            StPresent: begin
                if (bus_io.cpu_int_ack) begin
                    state_d = StHoldoff;
                end else if (withdraw) begin
                    state_d = StIdle;
                end
            end
            StHoldoff: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_d = grant_q;
        vec_d   = '0;
        lvl_d   = '0;
        req_d   = (state_d == StPresent);
        ack_d   = '0;
        if (state_q == StIdle && any_eligible) begin
            grant_d = winner;
            vec_d   = bus_io.src_vector[VEC_W*winner +: VEC_W];
            lvl_d   = bus_io.src_level[LevelW*winner +: LevelW];
        end else if (state_d == StPresent) begin
            vec_d = vec_q;
            lvl_d = lvl_q;
        end
        if (state_q == StPresent && bus_io.cpu_int_ack) begin
            ack_d[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            vec_q   <= '0;
            lvl_q   <= '0;
            req_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            grant_q <= grant_d;
            vec_q   <= vec_d;
            lvl_q   <= lvl_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
        end
    end

    assign bus_io.cpu_int_req    = req_q;
    assign bus_io.cpu_int_vector = vec_q;
    assign bus_io.cpu_int_level  = lvl_q;
    assign bus_io.src_ack        = ack_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model of the grant/ack rules.
module tb_intr_arbiter;
    import intr_pkg::*;

    localparam int NS = 4;
    localparam int VW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    intr_arbiter_if #(.NUM_SRC(NS), .VEC_W(VW)) bus ();

    intr_arbiter #(
        .NUM_SRC (NS),
        .VEC_W   (VW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    string step   = "init";

    // Model state: granted source (-1 none), source acked this cycle (-1 none),
    // pending holdoff cycle, and the latched vector/level of the grant.
    int m_gnt  = -1;
    int m_ack  = -1;
    bit m_hold = 1'b0;
    int m_vec  = 0;
    int m_lvl  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s/%s: got %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input bit req, input int lvl, input int vec);
        bus.src_req[i]              = req;
        bus.src_level[3*i +: 3]     = lvl[2:0];
        bus.src_vector[VW*i +: VW]  = vec[VW-1:0];
    endtask

    function automatic int src_lvl(input int i);
        return int'(bus.src_level[3*i +: 3]);
    endfunction

    // Highest level first, then lowest index within that level.
    function automatic int ref_winner();
        for (int lv = 7; lv >= 1; lv--) begin
            if (lv > int'(bus.cpu_ipl)) begin
                for (int i = 0; i < NS; i++) begin
                    if (bus.src_req[i] && src_lvl(i) == lv) return i;
                end
            end
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (reset) begin
            m_gnt = -1; m_ack = -1; m_hold = 1'b0; m_vec = 0; m_lvl = 0;
        end else if (m_gnt >= 0) begin
            if (bus.cpu_int_ack) begin
                m_ack = m_gnt; m_gnt = -1; m_hold = 1'b1;
            end else if (!bus.src_req[m_gnt] || src_lvl(m_gnt) <= int'(bus.cpu_ipl)) begin
                m_ack = -1; m_gnt = -1;
            end else begin
                m_ack = -1;
            end
        end else if (m_hold) begin
            m_hold = 1'b0; m_ack = -1;
        end else begin
            m_ack = -1;
            w = ref_winner();
            if (w >= 0) begin
                m_gnt = w;
                m_vec = int'(bus.src_vector[VW*w +: VW]);
                m_lvl = src_lvl(w);
            end
        end
    endtask

    // One clock: model the edge, let it happen, then compare all outputs.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("req", 32'(bus.cpu_int_req), 32'(m_gnt >= 0));
        chk("vec", 32'(bus.cpu_int_vector), (m_gnt >= 0) ? m_vec : 0);
        chk("lvl", 32'(bus.cpu_int_level), (m_gnt >= 0) ? m_lvl : 0);
        chk("ack", 32'(bus.src_ack), (m_ack >= 0) ? (32'd1 << m_ack) : 0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) set_src(i, 1'b0, 0, 0);
        bus.cpu_ipl     = 3'd0;
        bus.cpu_int_ack = 1'b0;
    endtask

    initial begin
        clear_all();
        reset = 1'b1;
        step = "reset";
        tick();
        tick();
        chk("rst_req", 32'(bus.cpu_int_req), 0);
        chk("rst_ack", 32'(bus.src_ack), 0);
        reset = 1'b0;
        tick();

        // 1: single source
        step = "single";
        set_src(2, 1'b1, 6, ClkVec);
        tick();
        chk("vec_0100", 32'(bus.cpu_int_vector), 32'o100);
        chk("lvl_6", 32'(bus.cpu_int_level), 6);
        tick();
        bus.cpu_int_ack = 1'b1;
        tick();
        chk("ack_src2", 32'(bus.src_ack), 32'b0100);
        bus.cpu_int_ack = 1'b0;
        set_src(2, 1'b0, 6, ClkVec);
        tick();
        chk("holdoff_ack0", 32'(bus.src_ack), 0);
        tick();

        // 2: level priority
        step = "prio";
        set_src(1, 1'b1, 4, TtiVec);
        set_src(3, 1'b1, 6, ClkVec);
        tick();
        chk("gnt3_vec", 32'(bus.cpu_int_vector), 32'o100);
        bus.cpu_int_ack = 1'b1;
        tick();
        bus.cpu_int_ack = 1'b0;
        set_src(3, 1'b0, 6, ClkVec);
        tick();
        tick();
        tick();
        chk("gnt1_vec", 32'(bus.cpu_int_vector), 32'o060);
        bus.cpu_int_ack = 1'b1;
        tick();
        bus.cpu_int_ack = 1'b0;
        set_src(1, 1'b0, 4, TtiVec);
        tick();
        tick();

        // 3: tie goes to lowest index
        step = "tie";
        set_src(0, 1'b1, 5, TtoVec);
        set_src(2, 1'b1, 5, 8'o070);
        tick();
        chk("gnt0_vec", 32'(bus.cpu_int_vector), 32'o064);
        bus.cpu_int_ack = 1'b1;
        tick();
        chk("ack_src0", 32'(bus.src_ack), 32'b0001);
        bus.cpu_int_ack = 1'b0;
        set_src(0, 1'b0, 5, TtoVec);
        tick();
        tick();
        tick();
        chk("gnt2_vec", 32'(bus.cpu_int_vector), 32'o070);
        bus.cpu_int_ack = 1'b1;
        tick();
        bus.cpu_int_ack = 1'b0;
        clear_all();
        tick();
        tick();

        // 4: ipl masking and withdrawal
        step = "ipl";
        bus.cpu_ipl = 3'd6;
        set_src(1, 1'b1, 6, TtiVec);
        tick();
        tick();
        chk("masked", 32'(bus.cpu_int_req), 0);
        bus.cpu_ipl = 3'd5;
        tick();
        chk("unmasked", 32'(bus.cpu_int_req), 1);
        bus.cpu_ipl = 3'd7;
        tick();
        chk("withdrawn", 32'(bus.cpu_int_req), 0);
        chk("withdrawn_ack", 32'(bus.src_ack), 0);
        clear_all();
        tick();

        // 5: ack wins over same-cycle drop; ack in idle ignored
        step = "ackwin";
        set_src(0, 1'b1, 7, ClkVec);
        tick();
        bus.cpu_int_ack = 1'b1;
        set_src(0, 1'b0, 7, ClkVec);
        tick();
        chk("ack_src0", 32'(bus.src_ack), 32'b0001);
        bus.cpu_int_ack = 1'b0;
        tick();
        tick();
        bus.cpu_int_ack = 1'b1;
        tick();
        chk("idle_ack", 32'(bus.src_ack), 0);
        bus.cpu_int_ack = 1'b0;
        tick();

        // 6: reset during PRESENT, then re-grant
        step = "rstmid";
        set_src(3, 1'b1, 5, TtoVec);
        tick();
        reset = 1'b1;
        bus.cpu_int_ack = 1'b1;
        tick();
        chk("rst_req", 32'(bus.cpu_int_req), 0);
        chk("rst_ack", 32'(bus.src_ack), 0);
        reset = 1'b0;
        bus.cpu_int_ack = 1'b0;
        tick();
        chk("regrant", 32'(bus.cpu_int_req), 1);
        clear_all();
        tick();

        // Random traffic
        step = "random";
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_src(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 255)));
                end
            end
            if ($urandom_range(0, 7) == 0) bus.cpu_ipl = 3'($urandom_range(0, 7));
            bus.cpu_int_ack = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        clear_all();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
